// File: rtl/flash_ctrl.sv
// flash_ctrl: arbitrates the fetch (read-only) and data (read/write/erase)
// ports onto a single 1024x32 flash macro. One transaction at a time, each
// completed by a one-cycle acknowledge on the port that was granted.
module flash_ctrl #(
   parameter int ERASE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   // fetch port
   input  logic        i_req,
   input  logic [11:0] i_addr,
   output logic        i_ack,
   output logic [31:0] i_rdata,
   output logic        i_err,
   // data port
   input  logic        d_req,
   input  logic        d_we,
   input  logic        d_erase,
   input  logic [11:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        d_err,
   // flash macro
   output logic        f_rd_en,
   output logic        f_wr_en,
   output logic        f_erase_en,
   output logic [11:0] f_addr,
   output logic [31:0] f_data_in,
   input  logic [31:0] f_data_out,
   input  logic        f_busy
);

   typedef enum logic [2:0] {
      IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, ER_HOLD, ER_WAIT, DONE
   } state_t;

   state_t      state_q;
   logic        last_d_q;   // 1: data port had the most recent grant
   logic        gnt_d_q;    // 1: current transaction belongs to the data port
   logic [7:0]  cnt_q;      // erase hold down-counter
   logic        seen_q;     // f_busy observed low while in ER_WAIT

   logic        pick_d;
   logic [11:0] gnt_addr;

   // Round-robin pick: data wins when alone, or on a tie if fetch went last.
   always_comb begin
      pick_d   = d_req && (!i_req || !last_d_q);
      gnt_addr = pick_d ? d_addr : i_addr;
   end

   // Transaction sequencer; every output is a register set here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         last_d_q   <= 1'b1;
         gnt_d_q    <= 1'b0;
         cnt_q      <= 8'd0;
         seen_q     <= 1'b0;
         i_ack      <= 1'b0;
         i_rdata    <= 32'd0;
         i_err      <= 1'b0;
         d_ack      <= 1'b0;
         d_rdata    <= 32'd0;
         d_err      <= 1'b0;
         f_rd_en    <= 1'b0;
         f_wr_en    <= 1'b0;
         f_erase_en <= 1'b0;
         f_addr     <= 12'd0;
         f_data_in  <= 32'd0;
      end else begin
         // acks and rd/wr strobes are single-cycle pulses
         i_ack   <= 1'b0;
         d_ack   <= 1'b0;
         f_rd_en <= 1'b0;
         f_wr_en <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!f_busy && (i_req || d_req)) begin
                  last_d_q <= pick_d;
                  gnt_d_q  <= pick_d;
                  if (pick_d && d_erase) begin
                     // erase is whole-array: address is irrelevant, never errors
                     f_erase_en <= 1'b1;
                     cnt_q      <= 8'(ERASE_CYCLES);
                     seen_q     <= 1'b0;
                     state_q    <= ER_HOLD;
                  end else begin
                     f_addr <= gnt_addr;
                     if (pick_d) f_data_in <= d_wdata;
                     if (gnt_addr[11:10] != 2'b00) begin
                        // beyond the 1024-word array: answer at once, no strobe
                        if (pick_d) begin
                           d_ack   <= 1'b1;
                           d_err   <= 1'b1;
                           d_rdata <= 32'd0;
                        end else begin
                           i_ack   <= 1'b1;
                           i_err   <= 1'b1;
                           i_rdata <= 32'd0;
                        end
                        state_q <= DONE;
                     end else if (pick_d && d_we) begin
                        f_wr_en <= 1'b1;
                        state_q <= WR_ISSUE;
                     end else begin
                        f_rd_en <= 1'b1;
                        state_q <= RD_ISSUE;
                     end
                  end
               end
            end
            RD_ISSUE: state_q <= RD_WAIT;
            RD_WAIT: begin
               // flash data is valid the cycle after f_rd_en was sampled
               if (gnt_d_q) begin
                  d_rdata <= f_data_out;
                  d_err   <= 1'b0;
                  d_ack   <= 1'b1;
               end else begin
                  i_rdata <= f_data_out;
                  i_err   <= 1'b0;
                  i_ack   <= 1'b1;
               end
               state_q <= DONE;
            end
            WR_ISSUE: begin
               d_err   <= 1'b0;
               d_ack   <= 1'b1;
               state_q <= DONE;
            end
            ER_HOLD: begin
               if (cnt_q <= 8'd1) begin
                  f_erase_en <= 1'b0;
                  cnt_q      <= 8'd0;
                  state_q    <= ER_WAIT;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            ER_WAIT: begin
               // ack lands on the edge after the one that saw busy low
               if (seen_q) begin
                  seen_q  <= 1'b0;
                  d_err   <= 1'b0;
                  d_ack   <= 1'b1;
                  state_q <= DONE;
               end else if (!f_busy) begin
                  seen_q <= 1'b1;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_flash_ctrl.sv
// Directed testbench for flash_ctrl with a small behavioural flash model.
module tb_flash_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        i_req = 1'b0;
   logic [11:0] i_addr = 12'd0;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        i_err;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic        d_erase = 1'b0;
   logic [11:0] d_addr = 12'd0;
   logic [31:0] d_wdata = 32'd0;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        d_err;
   logic        f_rd_en, f_wr_en, f_erase_en;
   logic [11:0] f_addr;
   logic [31:0] f_data_in;
   logic [31:0] f_data_out = 32'd0;
   logic        f_busy;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   always #5 clk = ~clk;

   flash_ctrl #(.ERASE_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
      .d_req(d_req), .d_we(d_we), .d_erase(d_erase), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
      .f_rd_en(f_rd_en), .f_wr_en(f_wr_en), .f_erase_en(f_erase_en),
      .f_addr(f_addr), .f_data_in(f_data_in), .f_data_out(f_data_out), .f_busy(f_busy)
   );

   // flash model: busy from first sampled erase_en until 3 cycles after the last
   logic [31:0] mem [0:1023];
   logic        m_busy = 1'b0;
   logic        force_busy = 1'b0;
   int          hold = 0;
   logic        bd_we = 1'b0;
   logic [9:0]  bd_addr = 10'd0;
   logic [31:0] bd_data = 32'd0;
   assign f_busy = m_busy | force_busy;

   always @(posedge clk) begin
      if (bd_we) mem[bd_addr] <= bd_data;
      if (f_wr_en) mem[f_addr[9:0]] <= f_data_in;
      if (f_rd_en) f_data_out <= mem[f_addr[9:0]];
      if (f_erase_en) begin
         for (int k = 0; k < 1024; k++) mem[k] <= 32'hFFFF_FFFF;
         m_busy <= 1'b1;
         hold   <= 3;
      end else if (hold != 0) begin
         hold <= hold - 1;
         if (hold == 1) m_busy <= 1'b0;
      end
   end

   // strobe / ack activity counters
   int rd_cnt = 0, wr_cnt = 0, er_cnt = 0, ovl_cnt = 0;
   always @(negedge clk) begin
      if (f_rd_en)    rd_cnt++;
      if (f_wr_en)    wr_cnt++;
      if (f_erase_en) er_cnt++;
      if ((32'(f_rd_en) + 32'(f_wr_en) + 32'(f_erase_en)) > 1) ovl_cnt++;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [9:0] a, input logic [31:0] v);
      bd_we = 1'b1; bd_addr = a; bd_data = v;
      tick();
      bd_we = 1'b0;
   endtask

   task automatic test_reset;
      #1 rst_n = 1'b0;
      #1;
      tot_cnt++;
      if ({i_ack, i_err, d_ack, d_err, f_rd_en, f_wr_en, f_erase_en} !== 7'd0)
         $display("FAIL reset_ctl: got %b exp 0", {i_ack, i_err, d_ack, d_err, f_rd_en, f_wr_en, f_erase_en});
      else pass_cnt++;
      tot_cnt++;
      if ({i_rdata, d_rdata, f_addr, f_data_in} !== 108'd0)
         $display("FAIL reset_data: got %h exp 0", {i_rdata, d_rdata, f_addr, f_data_in});
      else pass_cnt++;
      preload(10'h005, 32'hDEAD_BEEF);
      preload(10'h010, 32'h1111_1111);
      preload(10'h020, 32'h2222_2222);
      @(negedge clk) rst_n = 1'b1;
      tick();
   endtask

   task automatic test_fetch;
      int rd0;
      rd0 = rd_cnt;
      i_addr = 12'h005; i_req = 1'b1;
      tick(); // cycle 0
      tot_cnt++;
      if ({f_rd_en, f_addr} !== {1'b1, 12'h005})
         $display("FAIL fetch_c0_strobe: got rd=%b addr=%h exp rd=1 addr=005", f_rd_en, f_addr);
      else pass_cnt++;
      tick(); // cycle 1
      tot_cnt++;
      if ({f_rd_en, i_ack} !== 2'b00)
         $display("FAIL fetch_c1: got rd=%b ack=%b exp 0 0", f_rd_en, i_ack);
      else pass_cnt++;
      tick(); // cycle 2
      tot_cnt++;
      if ({i_ack, i_err, i_rdata} !== {1'b1, 1'b0, 32'hDEAD_BEEF})
         $display("FAIL fetch_c2_ack: got ack=%b err=%b data=%h exp 1 0 deadbeef", i_ack, i_err, i_rdata);
      else pass_cnt++;
      i_req = 1'b0;
      tick(); // cycle 3
      tot_cnt++;
      if ({i_ack, i_rdata} !== {1'b0, 32'hDEAD_BEEF})
         $display("FAIL fetch_c3_hold: got ack=%b data=%h exp 0 deadbeef", i_ack, i_rdata);
      else pass_cnt++;
      tot_cnt++;
      if (rd_cnt - rd0 !== 1)
         $display("FAIL fetch_rd_pulses: got %0d exp 1", rd_cnt - rd0);
      else pass_cnt++;
   endtask

   task automatic test_write_read;
      int wr0, lat;
      bit got;
      wr0 = wr_cnt;
      d_addr = 12'h3FF; d_wdata = 32'h1234_5678; d_we = 1'b1; d_req = 1'b1;
      tick(); // cycle 0
      tot_cnt++;
      if ({f_wr_en, f_addr, f_data_in} !== {1'b1, 12'h3FF, 32'h1234_5678})
         $display("FAIL wr_c0: got wr=%b addr=%h data=%h exp 1 3ff 12345678", f_wr_en, f_addr, f_data_in);
      else pass_cnt++;
      tick(); // cycle 1
      tot_cnt++;
      if ({f_wr_en, d_ack, d_err} !== 3'b010)
         $display("FAIL wr_c1_ack: got wr=%b ack=%b err=%b exp 0 1 0", f_wr_en, d_ack, d_err);
      else pass_cnt++;
      d_req = 1'b0; d_we = 1'b0;
      tick();
      tot_cnt++;
      if (d_ack !== 1'b0) $display("FAIL wr_ack_width: got %b exp 0", d_ack);
      else pass_cnt++;
      tot_cnt++;
      if (wr_cnt - wr0 !== 1) $display("FAIL wr_pulses: got %0d exp 1", wr_cnt - wr0);
      else pass_cnt++;
      d_req = 1'b1;
      got = 1'b0; lat = 0;
      for (int c = 0; c < 10 && !got; c++) begin
         tick();
         if (d_ack) begin got = 1'b1; lat = c; end
      end
      tot_cnt++;
      if ({got, d_rdata, d_err} !== {1'b1, 32'h1234_5678, 1'b0})
         $display("FAIL rd_back: got ack=%b data=%h err=%b exp 1 12345678 0", got, d_rdata, d_err);
      else pass_cnt++;
      tot_cnt++;
      if (lat !== 2) $display("FAIL rd_latency: got %0d exp 2", lat);
      else pass_cnt++;
      d_req = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back;
      int n, first_c, last_c, both;
      bit is_d;
      logic [31:0] dat;
      n = 0; first_c = 0; last_c = 0; both = 0;
      i_addr = 12'h010; d_addr = 12'h020; d_we = 1'b0;
      i_req = 1'b1; d_req = 1'b1;
      for (int c = 0; c < 40 && n < 4; c++) begin
         tick();
         if (i_ack && d_ack) both++;
         if (i_ack || d_ack) begin
            is_d = d_ack;
            dat  = d_ack ? d_rdata : i_rdata;
            tot_cnt++;
            if (is_d !== n[0])
               $display("FAIL b2b_order%0d: got port_d=%b exp %b", n, is_d, n[0]);
            else pass_cnt++;
            tot_cnt++;
            if (dat !== (n[0] ? 32'h2222_2222 : 32'h1111_1111))
               $display("FAIL b2b_data%0d: got %h exp %h", n, dat, n[0] ? 32'h2222_2222 : 32'h1111_1111);
            else pass_cnt++;
            if (n == 0) first_c = c;
            last_c = c;
            n++;
         end
      end
      i_req = 1'b0; d_req = 1'b0;
      tot_cnt++;
      if (n !== 4) $display("FAIL b2b_count: got %0d acks exp 4", n);
      else pass_cnt++;
      tot_cnt++;
      if (last_c - first_c !== 12) $display("FAIL b2b_spacing: got %0d cycles exp 12", last_c - first_c);
      else pass_cnt++;
      tot_cnt++;
      if (both !== 0) $display("FAIL b2b_overlap: got %0d exp 0", both);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_oor;
      int s0;
      s0 = rd_cnt + wr_cnt + er_cnt;
      i_addr = 12'h400; i_req = 1'b1;
      tick(); // cycle 0
      tot_cnt++;
      if ({i_ack, i_err, i_rdata} !== {1'b1, 1'b1, 32'd0})
         $display("FAIL oor_ack: got ack=%b err=%b data=%h exp 1 1 0", i_ack, i_err, i_rdata);
      else pass_cnt++;
      i_req = 1'b0;
      tick();
      tot_cnt++;
      if ({i_ack, f_rd_en, f_wr_en, f_erase_en} !== 4'd0 || (rd_cnt + wr_cnt + er_cnt) !== s0)
         $display("FAIL oor_nostrobe: got ack=%b strobes=%0d exp 0 0", i_ack, rd_cnt + wr_cnt + er_cnt - s0);
      else pass_cnt++;
   endtask

   task automatic test_erase;
      int e0, ack_c, early;
      bit got;
      e0 = er_cnt; ack_c = -1; early = 0;
      d_addr = 12'h7FF; d_erase = 1'b1; d_we = 1'b1; d_req = 1'b1;
      tick(); // cycle 0
      tot_cnt++;
      if (f_erase_en !== 1'b1) $display("FAIL er_c0: got %b exp 1", f_erase_en);
      else pass_cnt++;
      i_addr = 12'h005; i_req = 1'b1;
      for (int c = 1; c < 30 && ack_c < 0; c++) begin
         tick();
         if (d_ack) ack_c = c;
         else if (i_ack || f_rd_en) early++;
      end
      tot_cnt++;
      if (ack_c !== 9) $display("FAIL er_ack_cycle: got %0d exp 9", ack_c);
      else pass_cnt++;
      tot_cnt++;
      if (d_err !== 1'b0) $display("FAIL er_err: got %b exp 0", d_err);
      else pass_cnt++;
      tot_cnt++;
      if (er_cnt - e0 !== 4) $display("FAIL er_len: got %0d exp 4", er_cnt - e0);
      else pass_cnt++;
      tot_cnt++;
      if (early !== 0) $display("FAIL er_fetch_early: got %0d exp 0", early);
      else pass_cnt++;
      d_req = 1'b0; d_erase = 1'b0; d_we = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         tick();
         if (i_ack) got = 1'b1;
      end
      tot_cnt++;
      if ({got, i_rdata} !== {1'b1, 32'hFFFF_FFFF})
         $display("FAIL er_then_fetch: got ack=%b data=%h exp 1 ffffffff", got, i_rdata);
      else pass_cnt++;
      i_req = 1'b0;
      tick();
      tot_cnt++;
      if (ovl_cnt !== 0) $display("FAIL strobe_overlap: got %0d exp 0", ovl_cnt);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid;
      int early;
      bit got;
      early = 0;
      d_erase = 1'b1; d_req = 1'b1;
      tick(); // cycle 0, ER_HOLD
      i_addr = 12'h005; i_req = 1'b1; force_busy = 1'b1;
      tick();
      tot_cnt++;
      if (f_erase_en !== 1'b1) $display("FAIL rst_mid_pre: got %b exp 1", f_erase_en);
      else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      tot_cnt++;
      if ({i_ack, i_err, d_ack, d_err, f_rd_en, f_wr_en, f_erase_en, f_addr, i_rdata, d_rdata, f_data_in} !== 115'd0)
         $display("FAIL rst_mid_outputs: got %h exp 0",
                  {i_ack, i_err, d_ack, d_err, f_rd_en, f_wr_en, f_erase_en, f_addr, i_rdata, d_rdata, f_data_in});
      else pass_cnt++;
      d_req = 1'b0; d_erase = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (i_ack || f_rd_en || d_ack) early++;
      end
      tot_cnt++;
      if (early !== 0) $display("FAIL rst_mid_busy_hold: got %0d exp 0", early);
      else pass_cnt++;
      force_busy = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         tick();
         if (i_ack) got = 1'b1;
      end
      tot_cnt++;
      if ({got, i_err, i_rdata} !== {1'b1, 1'b0, 32'hFFFF_FFFF})
         $display("FAIL rst_mid_fetch: got ack=%b err=%b data=%h exp 1 0 ffffffff", got, i_err, i_rdata);
      else pass_cnt++;
      i_req = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_write_read();
      test_back_to_back();
      test_oor();
      test_erase();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
